// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a valid/ack holding register and overrun/framing strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling; every output timing then moves one cycle later.
module uart_rx #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [7:0]           data,
    output logic                 valid,
    input  logic                 ack,
    output logic                 overrun,
    output logic                 frame_err
);

    localparam int CW = DIV_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n, cnt_run;
    logic [7:0]     shift, shift_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic           deliver, ferr;

    logic           rx_meta, rxs, rxs_d;
    logic           sample_bit;
    logic [CW-1:0]  period_m1, half, first_load;

    assign period_m1 = CW'(div) + CW'(1);
    assign half      = (CW'(div) + CW'(2)) >> 1;

`ifdef UART_RX_MAJORITY_EN
    logic rxs_d2;

    // The counter expires one cycle after s_k, when rxs_d2/rxs_d/rxs hold s_k-1/s_k/s_k+1.
    assign first_load = half;
    assign sample_bit = (rxs_d2 & rxs_d) | (rxs_d2 & rxs) | (rxs_d & rxs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rxs_d2 <= 1'b1;
        else     rxs_d2 <= rxs_d;
    end
`else
    assign first_load = half - CW'(1);
    assign sample_bit = rxs;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shift   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
        end
    end

    assign cnt_run = (cnt == '0) ? period_m1 : cnt - CW'(1);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        deliver   = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs && rxs_d) begin
                    state_n = START;
                    cnt_n   = first_load;
                end
            end
            START: begin
                cnt_n = cnt_run;
                if (cnt == '0) begin
                    if (sample_bit) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
            end
            DATA: begin
                cnt_n = cnt_run;
                if (cnt == '0) begin
                    shift_n   = {sample_bit, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt_run;
                if (cnt == '0) begin
                    if (sample_bit) begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // An ack coinciding with a delivery frees the register just in time for the new byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= ferr;
            if (deliver) begin
                if (!valid || ack) begin
                    data  <= shift;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
